change_dispenser: RTL and testbench

- Controller that returns change after a vend.
- Takes a change amount in cents from the vendor FSM and sequences a coin hopper one coin at a time, using greedy quarter/dime/nickel selection limited by tracked coin stock.
- Handshakes each coin with the hopper and paces coins with the slow clock-enable tick.
- Reports completion, any undispensable remainder, and hopper faults.

---
 rtl/vendor_pkg.sv | 39 +++
 rtl/coin_stock.sv | 25 ++
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 tb/tb_change_dispenser.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vendor_pkg.sv
// Shared vending definitions: coin codes and values, amount width, change dispenser state encoding.
package vendor_pkg;

  localparam int unsigned COIN_W = 3;
  localparam int unsigned AMT_W  = 8;

  typedef logic [COIN_W-1:0] coin_t;

  // One-hot coin codes, same encoding as the coin buttons
  localparam coin_t COIN_NONE = 3'd0;
  localparam coin_t NICKEL    = 3'd1;
  localparam coin_t DIME      = 3'd2;
  localparam coin_t QUARTER   = 3'd4;

  localparam logic [AMT_W-1:0] VAL_NICKEL  = 8'd5;
  localparam logic [AMT_W-1:0] VAL_DIME    = 8'd10;
  localparam logic [AMT_W-1:0] VAL_QUARTER = 8'd25;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EJECT  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } disp_state_e;

  function automatic logic [AMT_W-1:0] coin_value(input coin_t c);
    logic [AMT_W-1:0] v;
    v = '0;
    case (c)
      QUARTER: v = VAL_QUARTER;
      DIME:    v = VAL_DIME;
      NICKEL:  v = VAL_NICKEL;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Single coin-type stock counter: loads INIT on reset, MAX on refill, counts down per dispensed coin.
module coin_stock
  import vendor_pkg::*;
#(
  parameter int unsigned INIT = 8,
  parameter int unsigned MAX  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [AMT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= AMT_W'(INIT);
    end else if (load) begin
      count <= AMT_W'(MAX);
    end else if (dec && (count != '0)) begin
      count <= count - AMT_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Returns change one coin at a time: greedy quarter/dime/nickel choice bounded by stock,
// per-coin hopper handshake with tick-paced gap and ack timeout.
module change_dispenser
  import vendor_pkg::*;
#(
  parameter int unsigned STOCK_INIT    = 8,
  parameter int unsigned STOCK_MAX     = 20,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [AMT_W-1:0] change,
  input  logic             refill,
  input  logic             eject_ack,
  output logic [COIN_W-1:0] eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] shortfall,
  output logic [AMT_W-1:0] stock_q,
  output logic [AMT_W-1:0] stock_d,
  output logic [AMT_W-1:0] stock_n
);

  localparam int unsigned CNT_W = 8;

  disp_state_e      state, state_nx;
  logic [AMT_W-1:0] remaining, remaining_nx;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nx;
  coin_t            coin, coin_nx;
  logic             flag, flag_nx;
  logic [AMT_W-1:0] shortfall_nx;
  coin_t            pick_c;
  coin_t            dec_sel_c;
  logic             refill_c;

  // Greedy choice limited by what is actually in stock
  always_comb begin
    pick_c = COIN_NONE;
    if ((remaining >= VAL_QUARTER) && (stock_q != '0)) begin
      pick_c = QUARTER;
    end else if ((remaining >= VAL_DIME) && (stock_d != '0)) begin
      pick_c = DIME;
    end else if ((remaining >= VAL_NICKEL) && (stock_n != '0)) begin
      pick_c = NICKEL;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    tick_cnt_nx  = tick_cnt;
    coin_nx      = coin;
    flag_nx      = flag;
    shortfall_nx = shortfall;
    dec_sel_c    = COIN_NONE;
    refill_c     = 1'b0;
    unique case (state)
      S_IDLE: begin
        refill_c = refill;
        if (start) begin
          remaining_nx = change;
          shortfall_nx = '0;
          state_nx     = S_SELECT;
        end
      end
      S_SELECT: begin
        coin_nx = pick_c;
        if (pick_c != COIN_NONE) begin
          tick_cnt_nx = '0;
          state_nx    = S_EJECT;
        end else begin
          shortfall_nx = remaining;
          state_nx     = S_FINISH;
        end
      end
      S_EJECT: begin
        // Ack takes priority over a coincident timeout tick
        if (eject_ack) begin
          remaining_nx = remaining - coin_value(coin);
          dec_sel_c    = coin;
          tick_cnt_nx  = '0;
          state_nx     = S_GAP;
        end else if (tick) begin
          if ((tick_cnt + CNT_W'(1)) >= CNT_W'(TIMEOUT_TICKS)) begin
            shortfall_nx = remaining;
            flag_nx      = 1'b1;
            state_nx     = S_FINISH;
          end else begin
            tick_cnt_nx = tick_cnt + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if ((GAP_TICKS == 0) || (tick && ((tick_cnt + CNT_W'(1)) >= CNT_W'(GAP_TICKS)))) begin
          state_nx = S_SELECT;
        end else if (tick) begin
          tick_cnt_nx = tick_cnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        flag_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State plus registered outputs derived from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      tick_cnt  <= '0;
      coin      <= COIN_NONE;
      flag      <= 1'b0;
      shortfall <= '0;
      eject     <= COIN_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      tick_cnt  <= tick_cnt_nx;
      coin      <= coin_nx;
      flag      <= flag_nx;
      shortfall <= shortfall_nx;
      eject     <= (state_nx == S_EJECT) ? coin_nx : COIN_NONE;
      busy      <= (state_nx != S_IDLE);
      done      <= (state_nx == S_FINISH);
      fault     <= (state_nx == S_FINISH) && flag_nx;
    end
  end

  coin_stock #(.INIT(STOCK_INIT), .MAX(STOCK_MAX)) u_stock_q (
    .clock (clock),
    .reset (reset),
    .load  (refill_c),
    .dec   (dec_sel_c == QUARTER),
    .count (stock_q)
  );

  coin_stock #(.INIT(STOCK_INIT), .MAX(STOCK_MAX)) u_stock_d (
    .clock (clock),
    .reset (reset),
    .load  (refill_c),
    .dec   (dec_sel_c == DIME),
    .count (stock_d)
  );

  coin_stock #(.INIT(STOCK_INIT), .MAX(STOCK_MAX)) u_stock_n (
    .clock (clock),
    .reset (reset),
    .load  (refill_c),
    .dec   (dec_sel_c == NICKEL),
    .count (stock_n)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Directed vector bench for change_dispenser: one dispense sequence per table entry, plus reset abort.
module tb_change_dispenser;
  import vendor_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick;
  logic        start;
  logic [7:0]  change;
  logic        refill;
  logic        eject_ack;
  logic [2:0]  eject;
  logic        busy;
  logic        done;
  logic        fault;
  logic [7:0]  shortfall;
  logic [7:0]  stock_q;
  logic [7:0]  stock_d;
  logic [7:0]  stock_n;

  always #5 clock = ~clock;

  change_dispenser #(
    .STOCK_INIT(8), .STOCK_MAX(20), .GAP_TICKS(2), .TIMEOUT_TICKS(6)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .change(change),
    .refill(refill), .eject_ack(eject_ack), .eject(eject), .busy(busy), .done(done),
    .fault(fault), .shortfall(shortfall), .stock_q(stock_q), .stock_d(stock_d),
    .stock_n(stock_n)
  );

  typedef struct {
    logic [7:0]  chg;
    bit          rf;
    bit          ack;
    bit          poke;
    int          nc;
    logic [23:0] cs;   // coin i at cs[3*i +: 3]
    logic [7:0]  sf;
    bit          flt;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  n;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] chg, input bit rf, input bit ack, input bit poke,
                              input int nc, input logic [23:0] cs, input logic [7:0] sf,
                              input bit flt, input logic [7:0] q, input logic [7:0] d,
                              input logic [7:0] n);
    vec_t v;
    v.chg = chg; v.rf = rf; v.ack = ack; v.poke = poke; v.nc = nc; v.cs = cs;
    v.sf = sf; v.flt = flt; v.q = q; v.d = d; v.n = n;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [2:0] seen [8];
    logic [2:0] prev;
    int nseen  = 0;
    int lat    = -1;
    int nticks = 0;
    int ndone  = 0;
    bit got    = 1'b0;
    bit flt    = 1'b0;
    logic [7:0] sf_s, q_s, d_s, n_s;
    sf_s = '0; q_s = '0; d_s = '0; n_s = '0;
    for (int i = 0; i < 8; i++) seen[i] = '0;
    @(negedge clock);
    start = 1'b1; change = v.chg; refill = v.rf; eject_ack = 1'b0; tick = 1'b0;
    prev = eject;
    @(negedge clock);
    start = 1'b0; refill = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if ((eject != 3'd0) && (prev == 3'd0)) begin
        if (nseen < 8) seen[nseen] = eject;
        if (nseen == 0) lat = cyc;
        nseen++;
      end
      if (done) begin
        got = 1'b1; ndone++; flt = fault;
        sf_s = shortfall; q_s = stock_q; d_s = stock_d; n_s = stock_n;
        break;
      end
      prev = eject;
      eject_ack = v.ack && (eject != 3'd0);
      tick = ((cyc % 4) == 3);
      if (tick && (eject != 3'd0)) nticks++;
      start = v.poke && (cyc == 5);
      if (start) change = 8'd5;
      @(negedge clock);
    end
    start = 1'b0; eject_ack = 1'b0; tick = 1'b0;
    check($sformatf("v%0d done_seen", idx), int'(got), 1);
    check($sformatf("v%0d ncoins", idx), nseen, v.nc);
    for (int i = 0; i < 8; i++)
      if (i < nseen && i < v.nc)
        check($sformatf("v%0d coin%0d", idx, i), int'(seen[i]), int'(v.cs[3*i +: 3]));
    check($sformatf("v%0d shortfall", idx), int'(sf_s), int'(v.sf));
    check($sformatf("v%0d fault", idx), int'(flt), int'(v.flt));
    check($sformatf("v%0d stock_q", idx), int'(q_s), int'(v.q));
    check($sformatf("v%0d stock_d", idx), int'(d_s), int'(v.d));
    check($sformatf("v%0d stock_n", idx), int'(n_s), int'(v.n));
    if (v.nc > 0) check($sformatf("v%0d latency", idx), lat, 2);
    if (!v.ack) check($sformatf("v%0d timeout_ticks", idx), nticks, 6);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check($sformatf("v%0d done_count", idx), ndone, 1);
    check($sformatf("v%0d idle_busy", idx), int'(busy), 0);
    check($sformatf("v%0d held_shortfall", idx), int'(shortfall), int'(v.sf));
  endtask

  initial begin
    logic [2:0] prev;
    int nseen;
    reset = 1'b0; tick = 1'b0; start = 1'b0; change = '0; refill = 1'b0; eject_ack = 1'b0;

    // Change amount, refill, ack, poke, coin count, coins (last first), shortfall, fault, q, d, n
    vecs[0] = mk(8'd20,  0, 1, 0, 2, 24'({3'd2, 3'd2}), 8'd0, 0, 8'd8, 8'd6, 8'd8);
    vecs[1] = mk(8'd200, 0, 1, 0, 8, 24'({8{3'd4}}), 8'd0, 0, 8'd0, 8'd6, 8'd8);
    vecs[2] = mk(8'd35,  0, 1, 0, 4, 24'({3'd1, 3'd2, 3'd2, 3'd2}), 8'd0, 0, 8'd0, 8'd3, 8'd7);
    vecs[3] = mk(8'd30,  0, 1, 0, 3, 24'({3'd2, 3'd2, 3'd2}), 8'd0, 0, 8'd0, 8'd0, 8'd7);
    vecs[4] = mk(8'd30,  0, 1, 0, 6, 24'({6{3'd1}}), 8'd0, 0, 8'd0, 8'd0, 8'd1);
    vecs[5] = mk(8'd15,  0, 1, 0, 1, 24'(3'd1), 8'd10, 0, 8'd0, 8'd0, 8'd0);
    vecs[6] = mk(8'd0,   0, 1, 0, 0, 24'd0, 8'd0, 0, 8'd0, 8'd0, 8'd0);
    vecs[7] = mk(8'd5,   1, 0, 0, 1, 24'(3'd1), 8'd5, 1, 8'd20, 8'd20, 8'd20);
    vecs[8] = mk(8'd30,  1, 1, 1, 2, 24'({3'd1, 3'd4}), 8'd0, 0, 8'd19, 8'd20, 8'd19);
    vecs[9] = mk(8'd7,   0, 1, 0, 1, 24'(3'd1), 8'd2, 0, 8'd19, 8'd20, 8'd18);

    repeat (2) @(negedge clock);
    check("rst eject", int'(eject), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst fault", int'(fault), 0);
    check("rst shortfall", int'(shortfall), 0);
    check("rst stock_q", int'(stock_q), 8);
    check("rst stock_d", int'(stock_d), 8);
    check("rst stock_n", int'(stock_n), 8);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Abort with reset while the second quarter of 50 cents is being ejected
    @(negedge clock);
    start = 1'b1; change = 8'd50;
    prev = eject;
    @(negedge clock);
    start = 1'b0;
    nseen = 0;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      if ((eject != 3'd0) && (prev == 3'd0)) nseen++;
      if (nseen == 2) break;
      prev = eject;
      eject_ack = (eject != 3'd0);
      tick = ((cyc % 4) == 3);
      @(negedge clock);
    end
    eject_ack = 1'b0; tick = 1'b0;
    check("abort second_eject", nseen, 2);
    check("abort eject_before", int'(eject), int'(QUARTER));
    check("abort stock_q_before", int'(stock_q), 18);
    #2 reset = 1'b0;
    #1;
    check("abort eject", int'(eject), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort shortfall", int'(shortfall), 0);
    check("abort stock_q", int'(stock_q), 8);
    check("abort stock_d", int'(stock_d), 8);
    check("abort stock_n", int'(stock_n), 8);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("abort idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
